// File: rtl/cpu_run_ctrl.sv
// Run controller for the 64-bit CPU: sequences core reset, counts run/retire cycles, stops on halt or timeout.
// Latency: core_reset releases RESET_CYCLES edges after reset/start; done rises DRAIN_CYCLES edges after stop.
// Backpressure: none; start is honoured only in DONE and every output is registered.
module cpu_run_ctrl #(
  parameter int ADDR_W       = 64,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 25,
  parameter int HALT_REPEAT  = 3,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              retire,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int SAME_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [SAME_W-1:0]  SAME_HALT  = SAME_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]   CYC_LIMIT  = CNT_W'(MAX_CYCLES);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [SAME_W-1:0]   same_cnt;
  logic [ADDR_W-1:0]   last_pc;

  // A repeat of the previous valid PC extends the run; any other PC starts a new run of one.
  logic [SAME_W-1:0] same_next;
  logic [CNT_W-1:0]  cycle_next;
  logic              halt_hit;
  logic              timeout_hit;
  logic              retire_inc;

  assign same_next   = (pc == last_pc) ? same_cnt + SAME_W'(1) : SAME_W'(1);
  assign halt_hit    = pc_valid && (same_next == SAME_HALT);
  assign cycle_next  = cycle_count + CNT_W'(1);
  assign timeout_hit = (cycle_next == CYC_LIMIT);
  assign retire_inc  = retire && !(&retire_count);

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      drain_cnt    <= '0;
      same_cnt     <= '0;
      last_pc      <= '0;
      core_reset   <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      status       <= ST_NONE;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          core_reset <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RUN: begin
          cycle_count <= cycle_next;
          if (retire_inc) retire_count <= retire_count + CNT_W'(1);
          if (pc_valid) begin
            last_pc  <= pc;
            same_cnt <= same_next;
          end
          // Halt takes priority when both stop conditions land on the same edge.
          if (halt_hit || timeout_hit) begin
            status    <= halt_hit ? ST_HALT : ST_TIMEOUT;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (retire_inc) retire_count <= retire_count + CNT_W'(1);
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= DONE;
            running   <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end

        DONE: begin
          if (start) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            status       <= ST_NONE;
            cycle_count  <= '0;
            retire_count <= '0;
            same_cnt     <= '0;
            last_pc      <= '0;
          end
        end

        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected stop/done reports, a monitor checks them.
// Latency: stop reported on the halting/timeout edge, done DRAIN_CYCLES edges later.
// Backpressure: none; the monitor reacts to status and done transitions.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] pc;
  logic        pc_valid;
  logic        retire;
  logic        core_reset;
  logic        running;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_done;
    logic [1:0]  st;
    logic [31:0] cc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .ADDR_W(64), .CNT_W(32), .RESET_CYCLES(2), .MAX_CYCLES(25),
    .HALT_REPEAT(3), .DRAIN_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .retire(retire), .core_reset(core_reset), .running(running), .done(done),
    .status(status), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_stop(input logic [1:0] st, input logic [31:0] cc);
    exp_t e;
    e.is_done = 1'b0; e.st = st; e.cc = cc; e.rc = '0;
    q.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] st, input logic [31:0] cc, input logic [31:0] rc);
    exp_t e;
    e.is_done = 1'b1; e.st = st; e.cc = cc; e.rc = rc;
    q.push_back(e);
  endtask

  task automatic step(input logic [63:0] p, input logic v, input logic r);
    pc = p; pc_valid = v; retire = r;
    @(posedge clk); #1;
  endtask

  // Two hold edges with core_reset high, then RUN with running high.
  task automatic hold_seq(input string tag);
    step(64'h0, 1'b0, 1'b0);
    chk({tag, "_hold_edge1_core_reset"}, core_reset, 1);
    chk({tag, "_hold_edge1_running"}, running, 0);
    step(64'h0, 1'b0, 1'b0);
    chk({tag, "_hold_edge2_core_reset"}, core_reset, 0);
    chk({tag, "_hold_edge2_running"}, running, 1);
  endtask

  task automatic restart(input string tag);
    start = 1'b1;
    step(64'h0, 1'b0, 1'b0);
    start = 1'b0;
    chk({tag, "_restart_core_reset"}, core_reset, 1);
    chk({tag, "_restart_done"}, done, 0);
    chk({tag, "_restart_status"}, status, 0);
    chk({tag, "_restart_cycles"}, cycle_count, 0);
    chk({tag, "_restart_retires"}, retire_count, 0);
    hold_seq(tag);
  endtask

  // Monitor: a status leaving 00 is a stop report, a rising done is a completion report.
  logic [1:0] prev_status = 2'b00;
  logic       prev_done   = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (status != 2'b00 && prev_status == 2'b00) begin
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_stop: got status %0h with nothing expected", status);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("stop_kind", 64'(e.is_done), 0);
          chk("stop_status", status, e.st);
          chk("stop_cycles", cycle_count, e.cc);
        end
      end
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done with nothing expected");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_kind", 64'(e.is_done), 1);
          chk("done_status", status, e.st);
          chk("done_cycles", cycle_count, e.cc);
          chk("done_retires", retire_count, e.rc);
          chk("done_running", running, 0);
        end
      end
    end
    prev_status = status;
    prev_done   = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pc = '0; pc_valid = 1'b0; retire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_retires", retire_count, 0);
    reset = 1'b0;
    hold_seq("boot");

    // Reset between edges in RUN drops running at once.
    step(64'h10, 1'b1, 1'b1);
    step(64'h14, 1'b1, 1'b1);
    step(64'h18, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrun_rst_running", running, 0);
    chk("midrun_rst_core_reset", core_reset, 1);
    chk("midrun_rst_cycles", cycle_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    hold_seq("boot2");

    // Timeout: distinct PCs for 25 RUN cycles, retire every cycle including drain.
    push_stop(2'b10, 32'd25);
    push_done(2'b10, 32'd25, 32'd30);
    for (int i = 0; i < 25; i++) step(64'(i * 4), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(64'(200 + i * 4), 1'b1, 1'b1);
    chk("timeout_done", done, 1);
    for (int i = 0; i < 3; i++) step(64'h300, 1'b1, 1'b1);
    chk("done_ignores_retire", retire_count, 30);
    chk("done_holds_cycles", cycle_count, 25);
    chk("done_holds_status", status, 2);

    // Halt on 0,4,8,8,8 with a start pulse in RUN that must be ignored.
    restart("halt");
    push_stop(2'b01, 32'd5);
    push_done(2'b01, 32'd5, 32'd10);
    step(64'h0, 1'b1, 1'b1);
    start = 1'b1;
    step(64'h4, 1'b1, 1'b1);
    start = 1'b0;
    chk("start_in_run_core_reset", core_reset, 0);
    for (int i = 0; i < 3; i++) step(64'h8, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(64'h0, 1'b0, 1'b1);

    // Third repeat lands on RUN cycle 25: halt wins over timeout.
    restart("simul");
    push_stop(2'b01, 32'd25);
    push_done(2'b01, 32'd25, 32'd30);
    for (int i = 0; i < 22; i++) step(64'(i * 4), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(64'd200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(64'h0, 1'b0, 1'b1);

    // Invalid cycles in between do not break a repeat run.
    restart("gaps");
    push_stop(2'b01, 32'd5);
    push_done(2'b01, 32'd5, 32'd8);
    step(64'h8, 1'b1, 1'b1);
    step(64'h99, 1'b0, 1'b0);
    step(64'h8, 1'b1, 1'b1);
    step(64'h99, 1'b0, 1'b0);
    step(64'h8, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(64'h0, 1'b0, 1'b1);

    // A different valid PC restarts the repeat count: 8,C,8,8,8 halts on cycle 5.
    restart("break");
    push_stop(2'b01, 32'd5);
    push_done(2'b01, 32'd5, 32'd3);
    step(64'h8, 1'b1, 1'b0);
    step(64'hC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(64'h8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(64'h0, 1'b0, 1'(i % 2 == 0));

    // Reset in the middle of DRAIN clears everything without a clock edge.
    restart("middrain");
    push_stop(2'b01, 32'd3);
    for (int i = 0; i < 3; i++) step(64'h8, 1'b1, 1'b1);
    step(64'h0, 1'b0, 1'b1);
    step(64'h0, 1'b0, 1'b1);
    chk("middrain_running_before", running, 1);
    #1 reset = 1'b1;
    #1;
    chk("middrain_core_reset", core_reset, 1);
    chk("middrain_running", running, 0);
    chk("middrain_cycles", cycle_count, 0);
    chk("middrain_retires", retire_count, 0);
    chk("middrain_status", status, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    hold_seq("final");
    chk("final_done", done, 0);

    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller for the 64-bit pipelined CPU. It sequences core reset, counts run and retired-instruction cycles, and ends a run on a branch-to-self halt or on a cycle timeout.
- After the run ends, it drains the pipeline and reports a status.
- Sits beside CPU_64bit and drives its reset.
- Used both in simulation and on board bring-up, so test runs no longer depend on hard-coded cycle loops.

Parameters:
- ADDR_W, 64, PC width.
- CNT_W, 32, width of cycle_count and retire_count.
- RESET_CYCLES, 2, rising edges for which core_reset is held after controller reset or restart; must be >= 1.
- MAX_CYCLES, 25, RUN cycles before timeout; must be >= 1 and < 2^CNT_W.
- HALT_REPEAT, 3, consecutive valid samples of one PC that signal a halt; must be >= 2.
- DRAIN_CYCLES, 5, post-stop cycles that let the pipeline retire; 0 is allowed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high controller reset.
- start  in  1  single-cycle pulse; restarts a run from DONE only.
- pc  in  ADDR_W  retiring-stage PC.
- pc_valid  in  1  pc is meaningful this cycle.
- retire  in  1  one instruction retired this cycle.
- core_reset  out  1  reset to the CPU core.
- running  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- status  out  2  00 none, 01 halt, 10 timeout.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- retire_count  out  CNT_W  instructions retired since run start.

Behaviour:
- States: HOLD, RUN, DRAIN, DONE.
- Asynchronous reset (reset=1), with no clock edge needed:
  - state = HOLD.
  - core_reset = 1; running = 0; done = 0.
  - status = 00; cycle_count = 0; retire_count = 0.
  - Hold, drain and same-PC counters = 0; last_pc = 0.
  - Applies in any state, including mid-RUN and mid-DRAIN.
- HOLD:
  - core_reset = 1.
  - The hold counter increments on each rising edge with reset low.
  - On the RESET_CYCLES-th such edge: go to RUN and drive core_reset = 0, running = 1 (registered).
- RUN:
  - cycle_count increments every edge.
  - retire_count increments on each edge where retire = 1.
  - Halt tracking, only when pc_valid = 1:
    - If pc == last_pc, same_cnt += 1; otherwise same_cnt = 1.
    - last_pc <= pc.
    - Cycles with pc_valid = 0 leave last_pc and same_cnt unchanged.
  - Halt: on the edge where same_cnt reaches HALT_REPEAT, status <= 01 and go to DRAIN.
  - Timeout: on the edge where cycle_count becomes MAX_CYCLES, status <= 10 and go to DRAIN.
  - If halt and timeout occur on the same edge, halt wins: status = 01. cycle_count still takes its incremented value.
- DRAIN:
  - cycle_count is frozen; retire_count keeps counting.
  - core_reset = 0; running = 1.
  - After DRAIN_CYCLES edges, go to DONE.
  - If DRAIN_CYCLES = 0, RUN goes directly to DONE.
- DONE:
  - running = 0; done = 1; core_reset = 0.
  - status and both counts are held, and retire input is ignored.
  - start = 1 on an edge:
    - Go to HOLD; core_reset <= 1.
    - Clear counts, status, same_cnt and last_pc.
  - start in any other state is ignored.
- Counters never wrap. cycle_count is bounded by MAX_CYCLES; retire_count saturates at 2^CNT_W-1.
- All outputs are registered, with no combinational path from input to output.

Test Plan:
- Reset sequence: assert reset for 2 cycles, then release → core_reset = 1 through 2 rising edges, then 0 with running = 1. Asserting reset between edges drops running immediately.
- Timeout: pc = 0,4,8,... on consecutive cycles with pc_valid = retire = 1 → on the 25th RUN edge, status = 10 and cycle_count = 25. After 5 drain edges, done = 1, retire_count = 30 and cycle_count is still 25.
- Halt: pc sequence 0,4,8,8,8, all valid, retire = 1 → status = 01 on the edge of the third 8, cycle_count = 5. done rises 5 edges later with retire_count = 10.
- Simultaneous events: pc reaches its third repeat exactly on RUN cycle 25 → status = 01, cycle_count = 25.
- pc_valid gaps: sequence 8, invalid, 8, invalid, 8 → halt detected. Sequence 8, 0xC, 8, 8 → no halt until a third consecutive valid 8.
- Restart and mid-run reset:
  - start pulsed in RUN → ignored.
  - start in DONE → HOLD with counts and status at 0, core_reset = 1 for 2 edges.
  - reset asserted mid-DRAIN → core_reset = 1 and counts = 0 with no clock edge.
